alu_issue_stage: RTL and testbench
==================================

// Module: alu_issue_stage
// PURPOSE
//  Decode/issue stage that sits directly upstream of the 32-bit ALU. It accepts
//  RV32I OP and OP-IMM instructions with their source register values, and
//  decodes them into the ALU inputs OP1, OP2 and OPCODE, plus the destination
//  register. The outputs are registered behind a valid/ready handshake with a
//  2-entry skid buffer, so both sides can stall without losing data.
// PARAMETERS
//  XLEN   32  datapath width (the ALU is 32-bit; only 32 is supported)
//  RD_W    5  destination register index width
// PORTS
//  CLK        in   1     rising-edge clock
//  RST_N      in   1     asynchronous active-low reset
//  FLUSH      in   1     synchronous drop of all held entries
//  IN_VALID   in   1     INSTR/RS1_VAL/RS2_VAL are valid
//  IN_READY   out  1     stage can accept this cycle
//  INSTR      in   32    RV32I instruction word
//  RS1_VAL    in   XLEN  value of x[rs1]
//  RS2_VAL    in   XLEN  value of x[rs2]
//  OUT_VALID  out  1     OP1/OP2/OPCODE/RD/ILLEGAL are valid
//  OUT_READY  in   1     consumer (ALU/writeback) accepts this cycle
//  OP1        out  XLEN  ALU operand 1
//  OP2        out  XLEN  ALU operand 2
//  OPCODE     out  4     ALU op: ADD0 SUB1 SLL2 SLT3 SLTU4 XOR5 SRL6 SRA7 OR8 AND9
//  RD         out  RD_W  destination register, INSTR[11:7]
//  ILLEGAL    out  1     entry is not a legal OP/OP-IMM instruction
// BEHAVIOUR
//  Reset: while RST_N=0 and after release, all outputs are 0, except IN_READY,
//   which is 1. Both buffer slots are empty.
//  Transfer rules:
//   - A transfer occurs when VALID&READY are both high on a rising CLK edge.
//   - An accepted instruction appears on the outputs in the next cycle
//     (latency 1) if the output slot is empty or draining.
//   - OUT_VALID holds until the consumer accepts. Outputs stay stable while
//     OUT_VALID=1 and OUT_READY=0.
//  Buffer states: EMPTY -> ONE (output slot full) -> TWO (skid slot also full).
//   - In TWO, IN_READY=0. IN_READY is a register output and never depends
//     combinationally on OUT_READY.
//   - Leaving TWO: the skid entry moves into the output slot on the first
//     accepted output.
//   - Simultaneous accept-in and accept-out in ONE: the state stays ONE and
//     the output slot takes the new entry.
//   - Order is strictly FIFO.
//  Decode, from INSTR[6:0]:
//   - 0110011 (OP): OP2 = RS2_VAL.
//   - 0010011 (OP-IMM): OP2 = sign-extended INSTR[31:20]. For shifts, OP2[4:0]
//     is the shamt.
//   - In both cases OP1 = RS1_VAL.
//  funct3 (INSTR[14:12]) to OPCODE:
//   - 000: ADD. OP with funct7=0100000 gives SUB. OP-IMM is always ADD.
//   - 001: SLL. 010: SLT. 011: SLTU. 100: XOR.
//   - 101: SRL if funct7=0000000, SRA if funct7=0100000.
//   - 110: OR. 111: AND.
//  Illegal instructions: any other major opcode, OP with any other funct7, or
//   OP-IMM shifts with any other funct7.
//   - The entry is still passed with ILLEGAL=1, OPCODE=4'hF and OP1=OP2=0, RD
//     as decoded.
//   - Sequencing is unchanged.
//  FLUSH=1 at an edge:
//   - Both slots are emptied, OUT_VALID=0 and IN_READY=1 next cycle.
//   - Any input handshake in that same cycle is discarded.
//   - FLUSH has priority over all transfers.
//  Reset mid-operation clears everything immediately (asynchronous). There is
//   no partial output.
// TESTING
//  1. Hold OUT_READY=1. Send add x3,x1,x2 with RS1=5, RS2=7 ->
//     next cycle OUT_VALID=1, OPCODE=0, OP1=5, OP2=7, RD=3.
//  2. Send addi imm=-1 (0xFFF) with RS1=10 -> OPCODE=0, OP2=0xFFFFFFFF.
//     Send srai shamt=4 with RS1=0x80000000 -> OPCODE=7, OP2[4:0]=4.
//  3. Hold OUT_READY=0 and offer 3 back-to-back instructions ->
//     2 accepted, IN_READY=0 on the 3rd. Release OUT_READY -> outputs drain
//     in order, 1 per cycle.
//  4. With 2 entries held, pulse FLUSH together with IN_VALID ->
//     next cycle OUT_VALID=0, IN_READY=1, and nothing is emitted.
//  5. Send INSTR=0x0000006F (JAL) -> ILLEGAL=1, OPCODE=0xF.
//     Send OP funct7=0000001 -> ILLEGAL=1.
//  6. Assert RST_N=0 while 2 entries are held -> all outputs go to 0
//     immediately (IN_READY=1 after release), and no stale entry appears
//     afterwards.

Source files
------------

// File: rtl/alu_issue_stage.sv
// ---------------------------------------------------------------------------
// alu_issue_stage
//   Decode/issue stage in front of the 32-bit ALU. Decodes RV32I OP and
//   OP-IMM instructions into ALU operands, an ALU opcode and the destination
//   register. Results are held in a 2-entry skid buffer (output slot + skid
//   slot) behind a valid/ready handshake on both sides.
//
// Ports
//   clk_i        rising-edge clock
//   rst_ni       asynchronous active-low reset
//   flush_i      synchronous drop of all held entries (wins over transfers)
//   in_valid_i   instr_i/rs1_val_i/rs2_val_i are valid
//   in_ready_o   stage can accept this cycle (registered)
//   instr_i      RV32I instruction word
//   rs1_val_i    value of x[rs1]
//   rs2_val_i    value of x[rs2]
//   out_valid_o  op1_o/op2_o/opcode_o/rd_o/illegal_o are valid
//   out_ready_i  consumer accepts this cycle
//   op1_o        ALU operand 1
//   op2_o        ALU operand 2
//   opcode_o     ALU op: ADD0 SUB1 SLL2 SLT3 SLTU4 XOR5 SRL6 SRA7 OR8 AND9
//   rd_o         destination register, instr[11:7]
//   illegal_o    entry is not a legal OP/OP-IMM instruction
//   state_o      buffer state (0 EMPTY, 1 ONE, 2 TWO), debug visibility
//
// Handshake: a transfer happens on a rising clk_i edge where valid and ready
//   are both high. The producer holds its payload stable until accepted;
//   outputs stay stable while out_valid_o=1 and out_ready_i=0.
// ---------------------------------------------------------------------------
module alu_issue_stage #(
    parameter int XLEN = 32,
    parameter int RD_W = 5
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            flush_i,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [31:0]     instr_i,
    input  logic [XLEN-1:0] rs1_val_i,
    input  logic [XLEN-1:0] rs2_val_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [XLEN-1:0] op1_o,
    output logic [XLEN-1:0] op2_o,
    output logic [3:0]      opcode_o,
    output logic [RD_W-1:0] rd_o,
    output logic            illegal_o,
    output logic [1:0]      state_o
);

    typedef enum logic [1:0] {S_EMPTY = 2'd0, S_ONE = 2'd1, S_TWO = 2'd2} state_t;

    typedef struct packed {
        logic            illegal;
        logic [RD_W-1:0] rd;
        logic [3:0]      opcode;
        logic [XLEN-1:0] op2;
        logic [XLEN-1:0] op1;
    } entry_t;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] F7_ZERO    = 7'b0000000;
    localparam logic [6:0] F7_ALT     = 7'b0100000;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_SLL  = 4'd2;
    localparam logic [3:0] ALU_SLT  = 4'd3;
    localparam logic [3:0] ALU_SLTU = 4'd4;
    localparam logic [3:0] ALU_XOR  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_OR   = 4'd8;
    localparam logic [3:0] ALU_AND  = 4'd9;
    localparam logic [3:0] ALU_ILL  = 4'hF;

    state_t state_q, state_d;
    entry_t out_q, skid_q, dec;
    logic   in_ready_q, in_ready_d;
    logic   in_fire, out_fire;
    logic   load_out_new, load_out_skid, load_skid;

    // rs1 index field is not needed: the register value arrives pre-read.
    logic unused_rs1_idx;
    assign unused_rs1_idx = ^instr_i[19:15];

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [3:0] base_op;
    logic       legal;

    assign funct3 = instr_i[14:12];
    assign funct7 = instr_i[31:25];

    always_comb begin
        unique case (funct3)
            3'b000:  base_op = ALU_ADD;
            3'b001:  base_op = ALU_SLL;
            3'b010:  base_op = ALU_SLT;
            3'b011:  base_op = ALU_SLTU;
            3'b100:  base_op = ALU_XOR;
            3'b101:  base_op = ALU_SRL;
            3'b110:  base_op = ALU_OR;
            default: base_op = ALU_AND;
        endcase
    end

    always_comb begin
        dec         = '0;
        dec.rd      = instr_i[7 +: RD_W];
        dec.op1     = rs1_val_i;
        dec.opcode  = base_op;
        legal       = 1'b1;
        unique case (instr_i[6:0])
            OPC_OP: begin
                dec.op2 = rs2_val_i;
                if (funct7 == F7_ZERO) begin
                    dec.opcode = base_op;
                end else if (funct7 == F7_ALT && funct3 == 3'b000) begin
                    dec.opcode = ALU_SUB;
                end else if (funct7 == F7_ALT && funct3 == 3'b101) begin
                    dec.opcode = ALU_SRA;
                end else begin
                    legal = 1'b0;
                end
            end
            OPC_OP_IMM: begin
                dec.op2 = {{(XLEN-12){instr_i[31]}}, instr_i[31:20]};
                // Only shifts constrain funct7; for other funct3 it is immediate.
                if (funct3 == 3'b001) begin
                    legal = (funct7 == F7_ZERO);
                end else if (funct3 == 3'b101) begin
                    if (funct7 == F7_ALT) begin
                        dec.opcode = ALU_SRA;
                    end else if (funct7 != F7_ZERO) begin
                        legal = 1'b0;
                    end
                end
            end
            default: legal = 1'b0;
        endcase
        if (!legal) begin
            dec.illegal = 1'b1;
            dec.opcode  = ALU_ILL;
            dec.op1     = '0;
            dec.op2     = '0;
        end
    end

    // ------------------------------------------------------------------
    // Buffer FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Buffer FSM: next state
    // ------------------------------------------------------------------
    assign in_fire  = in_valid_i & in_ready_q;
    assign out_fire = (state_q != S_EMPTY) & out_ready_i;

    always_comb begin
        state_d       = state_q;
        load_out_new  = 1'b0;
        load_out_skid = 1'b0;
        load_skid     = 1'b0;
        if (flush_i) begin
            state_d = S_EMPTY;
        end else begin
            unique case (state_q)
                S_EMPTY: begin
                    if (in_fire) begin
                        state_d      = S_ONE;
                        load_out_new = 1'b1;
                    end
                end
                S_ONE: begin
                    if (in_fire && out_fire) begin
                        load_out_new = 1'b1;
                    end else if (in_fire) begin
                        state_d   = S_TWO;
                        load_skid = 1'b1;
                    end else if (out_fire) begin
                        state_d = S_EMPTY;
                    end
                end
                S_TWO: begin
                    if (out_fire) begin
                        state_d       = S_ONE;
                        load_out_skid = 1'b1;
                    end
                end
                default: state_d = S_EMPTY;
            endcase
        end
        // Ready is registered from the next state so it never depends
        // combinationally on out_ready_i.
        in_ready_d = (state_d != S_TWO);
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_q      <= '0;
            skid_q     <= '0;
            in_ready_q <= 1'b1;
        end else begin
            in_ready_q <= in_ready_d;
            if (load_out_new) begin
                out_q <= dec;
            end else if (load_out_skid) begin
                out_q <= skid_q;
            end
            if (load_skid) begin
                skid_q <= dec;
            end
        end
    end

    // ------------------------------------------------------------------
    // Buffer FSM: outputs (payload forced to zero while not valid)
    // ------------------------------------------------------------------
    always_comb begin
        out_valid_o = (state_q != S_EMPTY);
        in_ready_o  = in_ready_q;
        state_o     = state_q;
        op1_o       = '0;
        op2_o       = '0;
        opcode_o    = '0;
        rd_o        = '0;
        illegal_o   = 1'b0;
        if (out_valid_o) begin
            op1_o     = out_q.op1;
            op2_o     = out_q.op2;
            opcode_o  = out_q.opcode;
            rd_o      = out_q.rd;
            illegal_o = out_q.illegal;
        end
    end

endmodule

// File: tb/tb_alu_issue_stage.sv
module tb_alu_issue_stage;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [3:0]  opcode;
    logic [4:0]  rd;
    logic        illegal;
    logic [1:0]  state;

    int checks = 0;
    int errors = 0;

    // {illegal, rd, opcode, op2, op1}
    logic [73:0] exp_q[$];

    alu_issue_stage #(.XLEN(32), .RD_W(5)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .flush_i     (flush),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .instr_i     (instr),
        .rs1_val_i   (rs1_val),
        .rs2_val_i   (rs2_val),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .op1_o       (op1),
        .op2_o       (op2),
        .opcode_o    (opcode),
        .rd_o        (rd),
        .illegal_o   (illegal),
        .state_o     (state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- helpers ----------------
    function automatic logic [31:0] r_type(input logic [6:0] f7, input logic [4:0] rs2,
                                           input logic [4:0] rs1, input logic [2:0] f3,
                                           input logic [4:0] rdi, input logic [6:0] opc);
        return {f7, rs2, rs1, f3, rdi, opc};
    endfunction

    function automatic logic [31:0] i_type(input logic [11:0] imm, input logic [4:0] rs1,
                                           input logic [2:0] f3, input logic [4:0] rdi,
                                           input logic [6:0] opc);
        return {imm, rs1, f3, rdi, opc};
    endfunction

    // Advance one clock; afterwards outputs are settled and inputs may change.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [31:0] e_op1,
                           input logic [31:0] e_op2, input logic [3:0] e_opc,
                           input logic [4:0] e_rd, input logic e_ill);
        chk({tag, ".valid"},   {31'd0, out_valid}, {31'd0, v});
        chk({tag, ".op1"},     op1, e_op1);
        chk({tag, ".op2"},     op2, e_op2);
        chk({tag, ".opcode"},  {28'd0, opcode}, {28'd0, e_opc});
        chk({tag, ".rd"},      {27'd0, rd}, {27'd0, e_rd});
        chk({tag, ".illegal"}, {31'd0, illegal}, {31'd0, e_ill});
    endtask

    task automatic chk_entry(input string tag);
        logic [73:0] obs;
        logic [73:0] exp;
        obs = {illegal, rd, opcode, op2, op1};
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $error("FAIL %s got=%0h exp=<queue empty>", tag, obs);
        end else begin
            exp = exp_q.pop_front();
            assert (out_valid === 1'b1 && obs === exp) else begin
                errors++;
                $error("FAIL %s got=v%0b %0h exp=v1 %0h", tag, out_valid, obs, exp);
            end
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] a,
                         input logic [31:0] b);
        in_valid = v;
        instr    = ins;
        rs1_val  = a;
        rs2_val  = b;
    endtask

    localparam logic [6:0] OP  = 7'b0110011;
    localparam logic [6:0] IMM = 7'b0010011;

    // ---------------- directed sequence ----------------
    initial begin
        logic [6:0] tf7 [8];
        logic [2:0] tf3 [8];
        logic [3:0] top [8];
        tf7 = '{7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h20, 7'h00, 7'h00};
        tf3 = '{3'b001, 3'b010, 3'b011, 3'b100, 3'b101, 3'b101, 3'b110, 3'b111};
        top = '{4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9};

        rst_n = 1'b0; flush = 1'b0; out_ready = 1'b0;
        drive(1'b0, 32'd0, 32'd0, 32'd0);

        // Reset state
        cyc(); cyc();
        chk("rst.in_ready", {31'd0, in_ready}, 32'd1);
        chk_out("rst", 1'b0, 32'd0, 32'd0, 4'd0, 5'd0, 1'b0);
        rst_n = 1'b1;
        cyc();
        chk("rel.in_ready", {31'd0, in_ready}, 32'd1);
        chk("rel.valid", {31'd0, out_valid}, 32'd0);

        // 1: add x3,x1,x2 with 5,7
        out_ready = 1'b1;
        drive(1'b1, r_type(7'h00, 5'd2, 5'd1, 3'b000, 5'd3, OP), 32'd5, 32'd7);
        cyc();
        chk_out("add", 1'b1, 32'd5, 32'd7, 4'd0, 5'd3, 1'b0);

        // 2: addi imm=-1, then srai shamt=4 back-to-back while draining
        drive(1'b1, i_type(12'hFFF, 5'd1, 3'b000, 5'd4, IMM), 32'd10, 32'h1234);
        cyc();
        chk_out("addi", 1'b1, 32'd10, 32'hFFFF_FFFF, 4'd0, 5'd4, 1'b0);
        drive(1'b1, i_type({7'h20, 5'd4}, 5'd1, 3'b101, 5'd5, IMM), 32'h8000_0000, 32'h55);
        cyc();
        chk_out("srai", 1'b1, 32'h8000_0000, 32'h0000_0404, 4'd7, 5'd5, 1'b0);
        chk("srai.shamt", {27'd0, op2[4:0]}, 32'd4);
        drive(1'b0, 32'd0, 32'd0, 32'd0);
        cyc();
        chk("drain.valid", {31'd0, out_valid}, 32'd0);

        // R-type funct3/funct7 table, one per cycle with consumer ready
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, r_type(tf7[i], 5'd2, 5'd1, tf3[i], 5'(10 + i), OP), 32'(100 + i), 32'(200 + i));
            cyc();
            chk_out($sformatf("tbl%0d", i), 1'b1, 32'(100 + i), 32'(200 + i), top[i], 5'(10 + i), 1'b0);
        end
        drive(1'b0, 32'd0, 32'd0, 32'd0);
        cyc();

        // 3: stall, fill both slots, third is refused, then FIFO drain
        out_ready = 1'b0;
        drive(1'b1, r_type(7'h20, 5'd2, 5'd1, 3'b000, 5'd6, OP), 32'd20, 32'd3);
        exp_q.push_back({1'b0, 5'd6, 4'd1, 32'd3, 32'd20});
        cyc();
        chk("stall1.in_ready", {31'd0, in_ready}, 32'd1);
        chk("stall1.state", {30'd0, state}, 32'd1);
        drive(1'b1, i_type(12'h0F0, 5'd1, 3'b100, 5'd7, IMM), 32'hFF, 32'd0);
        exp_q.push_back({1'b0, 5'd7, 4'd5, 32'hF0, 32'hFF});
        cyc();
        chk("stall2.in_ready", {31'd0, in_ready}, 32'd0);
        chk("stall2.state", {30'd0, state}, 32'd2);
        chk("stall2.op1", op1, 32'd20);
        drive(1'b1, r_type(7'h00, 5'd2, 5'd1, 3'b111, 5'd8, OP), 32'hAA, 32'hBB);
        cyc();
        chk("stall3.in_ready", {31'd0, in_ready}, 32'd0);
        chk_out("stall3.hold", 1'b1, 32'd20, 32'd3, 4'd1, 5'd6, 1'b0);
        drive(1'b0, 32'd0, 32'd0, 32'd0);
        chk_entry("fifo.first");
        out_ready = 1'b1;
        cyc();
        chk("fifo.in_ready", {31'd0, in_ready}, 32'd1);
        chk_entry("fifo.second");
        cyc();
        chk("fifo.empty", {31'd0, out_valid}, 32'd0);
        chk("fifo.q_left", 32'(exp_q.size()), 32'd0);

        // 4a: flush with two entries held plus an offered input
        out_ready = 1'b0;
        drive(1'b1, r_type(7'h00, 5'd2, 5'd1, 3'b000, 5'd1, OP), 32'd1, 32'd1);
        cyc();
        drive(1'b1, r_type(7'h00, 5'd2, 5'd1, 3'b000, 5'd2, OP), 32'd2, 32'd2);
        cyc();
        chk("pre_flush.state", {30'd0, state}, 32'd2);
        flush = 1'b1;
        drive(1'b1, r_type(7'h00, 5'd2, 5'd1, 3'b000, 5'd9, OP), 32'd9, 32'd9);
        cyc();
        flush = 1'b0;
        drive(1'b0, 32'd0, 32'd0, 32'd0);
        chk("flush2.valid", {31'd0, out_valid}, 32'd0);
        chk("flush2.in_ready", {31'd0, in_ready}, 32'd1);
        out_ready = 1'b1;
        cyc();
        chk("flush2.after", {31'd0, out_valid}, 32'd0);

        // 4b: flush in ONE while an input handshake is also taking place
        out_ready = 1'b0;
        drive(1'b1, r_type(7'h00, 5'd2, 5'd1, 3'b000, 5'd1, OP), 32'd1, 32'd1);
        cyc();
        flush = 1'b1;
        drive(1'b1, r_type(7'h00, 5'd2, 5'd1, 3'b000, 5'd2, OP), 32'd2, 32'd2);
        cyc();
        flush = 1'b0;
        drive(1'b0, 32'd0, 32'd0, 32'd0);
        chk("flush1.valid", {31'd0, out_valid}, 32'd0);
        chk("flush1.in_ready", {31'd0, in_ready}, 32'd1);
        out_ready = 1'b1;
        cyc();
        chk("flush1.after", {31'd0, out_valid}, 32'd0);

        // 5: illegal encodings
        drive(1'b1, 32'h0000_006F, 32'h1111, 32'h2222);
        cyc();
        chk_out("jal", 1'b1, 32'd0, 32'd0, 4'hF, 5'd0, 1'b1);
        drive(1'b1, r_type(7'h01, 5'd2, 5'd1, 3'b000, 5'd9, OP), 32'd3, 32'd4);
        cyc();
        chk_out("mul", 1'b1, 32'd0, 32'd0, 4'hF, 5'd9, 1'b1);
        drive(1'b1, i_type({7'h20, 5'd3}, 5'd1, 3'b001, 5'd11, IMM), 32'd3, 32'd4);
        cyc();
        chk_out("slli_f7", 1'b1, 32'd0, 32'd0, 4'hF, 5'd11, 1'b1);
        drive(1'b1, r_type(7'h20, 5'd2, 5'd1, 3'b100, 5'd12, OP), 32'd3, 32'd4);
        cyc();
        chk_out("xor_f7", 1'b1, 32'd0, 32'd0, 4'hF, 5'd12, 1'b1);
        drive(1'b1, i_type(12'h800, 5'd1, 3'b111, 5'd13, IMM), 32'hFFFF, 32'd0);
        cyc();
        chk_out("andi", 1'b1, 32'hFFFF, 32'hFFFF_F800, 4'd9, 5'd13, 1'b0);
        drive(1'b0, 32'd0, 32'd0, 32'd0);
        cyc();

        // 6: asynchronous reset with two entries held
        out_ready = 1'b0;
        drive(1'b1, r_type(7'h00, 5'd2, 5'd1, 3'b110, 5'd14, OP), 32'd7, 32'd8);
        cyc();
        drive(1'b1, r_type(7'h00, 5'd2, 5'd1, 3'b110, 5'd15, OP), 32'd9, 32'd10);
        cyc();
        drive(1'b0, 32'd0, 32'd0, 32'd0);
        chk("pre_rst.state", {30'd0, state}, 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        chk_out("async_rst", 1'b0, 32'd0, 32'd0, 4'd0, 5'd0, 1'b0);
        chk("async_rst.in_ready", {31'd0, in_ready}, 32'd1);
        cyc();
        rst_n = 1'b1;
        cyc();
        chk("post_rst.in_ready", {31'd0, in_ready}, 32'd1);
        out_ready = 1'b1;
        cyc();
        chk("post_rst.valid", {31'd0, out_valid}, 32'd0);
        cyc();
        chk("post_rst.valid2", {31'd0, out_valid}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
